lc3_mem_responder: RTL

- Memory-side responder for the LC-3 datapath: holds MAR/MDR and a word-addressed memory array, and answers memory-enable requests from the control FSM after a programmable number of wait states with a one-cycle ready pulse (the LC-3 "R" signal).
- Sits on the CPU bus opposite the control unit. The control unit initiates LD/ST/fetch accesses; this block services them.
- Replaces the zero-wait internal memory so that fetch, LD and ST can be exercised with realistic latency.

---
 rtl/lc3_mem_responder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/lc3_mem_responder.sv
// LC-3 memory-side responder: MAR/MDR plus word-addressed memory, answering
// memEN requests after WAIT_STATES idle cycles with a one-cycle ready pulse.
module lc3_mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Buss,
  input  logic        ldMAR,
  input  logic        ldMDR,
  input  logic        memEN,
  input  logic        memWE,
  output logic [15:0] mdr_out,
  output logic [15:0] mar_out,
  output logic        mem_ready,
  output logic        busy,
  output logic        access_err
);

  // state | meaning
  // IDLE  | accepts MAR/MDR loads and new requests
  // WAIT  | counting down wait states, registers frozen
  // DONE  | access complete, ready pulse
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $error("WAIT_STATES must be within 0..15");
  end
  if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 15) begin : g_bad_depth
    $error("DEPTH_LOG2 must be within 1..15");
  end

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;

  logic [15:0]           mem_q [DEPTH];
  logic                  mem_wr_en;
  logic [15:0]           mem_rd_data;
  logic [DEPTH_LOG2-1:0] addr;
  logic                  in_range;

  assign addr        = mar_q[DEPTH_LOG2-1:0];
  assign in_range    = (mar_q[15:DEPTH_LOG2] == '0);
  assign mem_rd_data = mem_q[addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      mar_q   <= 16'h0000;
      mdr_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
    end
  end

  // Memory contents survive reset; a reset edge suppresses a pending write.
  always_ff @(posedge clk) begin
    if (!rst && mem_wr_en) begin
      mem_q[addr] <= mdr_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    err_d     = err_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    mem_wr_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ldMAR) mar_d = Buss;
        if (ldMDR) mdr_d = Buss;
        if (memEN) begin
          we_d    = memWE;
          cnt_d   = WAIT_CNT;
          err_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!memEN) begin
          state_d = ST_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_DONE;
          err_d   = ~in_range;
          if (we_q) begin
            mem_wr_en = in_range;
          end else begin
            mdr_d = in_range ? mem_rd_data : 16'h0000;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    mdr_out    = mdr_q;
    mar_out    = mar_q;
    mem_ready  = (state_q == ST_DONE);
    busy       = (state_q != ST_IDLE);
    access_err = (state_q == ST_DONE) && err_q;
  end

endmodule
